// File: rtl/reg_file.sv
// 32 x 32-bit CPU register file: two combinational read ports plus a debug read
// port, one synchronous write port, register 0 hardwired to zero, saturating write counter.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] DbgReg,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] DbgData,
    output logic [15:0]       WriteCount
);

    localparam int DEPTH     = 2 ** ADDR_W;
    localparam int NUM_PORTS = 3;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [15:0]       r_write_count;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_rd_idx  [NUM_PORTS];
    logic [DATA_W-1:0] w_rd_data [NUM_PORTS];

    // Writes to index 0 are dropped entirely, including the count.
    assign w_wr_en = RegWrite && (WriteReg != {ADDR_W{1'b0}});

    // Storage and write counter; reset has priority over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
            r_write_count <= 16'h0000;
        end else if (w_wr_en) begin
            r_regs[WriteReg] <= WriteData;
            if (r_write_count != 16'hFFFF) begin
                r_write_count <= r_write_count + 16'h0001;
            end else begin
                r_write_count <= r_write_count;
            end
        end else begin
            r_write_count <= r_write_count;
        end
    end

    assign w_rd_idx[0] = ReadReg1;
    assign w_rd_idx[1] = ReadReg2;
    assign w_rd_idx[2] = DbgReg;

    // Independent read decoders; the bypass term forwards a pending write when enabled.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_rd_data[p] = {DATA_W{1'b0}};
            if ((BYPASS != 0) && w_wr_en && (w_rd_idx[p] == WriteReg)) begin
                w_rd_data[p] = WriteData;
            end else if (w_rd_idx[p] == {ADDR_W{1'b0}}) begin
                w_rd_data[p] = {DATA_W{1'b0}};
            end else begin
                w_rd_data[p] = r_regs[w_rd_idx[p]];
            end
        end
    end

    assign ReadData1  = w_rd_data[0];
    assign ReadData2  = w_rd_data[1];
    assign DbgData    = w_rd_data[2];
    assign WriteCount = r_write_count;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: two instances (no bypass / bypass) share stimulus;
// expectations come from an array-plus-counter model and are checked by a negedge monitor.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  DbgReg;
    logic [31:0] rd1_a, rd2_a, dbg_a, rd1_b, rd2_b, dbg_b;
    logic [15:0] wc_a, wc_b;

    always #5 clk = ~clk;

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_a (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .DbgReg(DbgReg), .ReadData1(rd1_a), .ReadData2(rd2_a),
        .DbgData(dbg_a), .WriteCount(wc_a)
    );

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .DbgReg(DbgReg), .ReadData1(rd1_b), .ReadData2(rd2_b),
        .DbgData(dbg_b), .WriteCount(wc_b)
    );

    typedef struct {
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_regs [32];
    int          model_cnt   = 0;
    bit          model_valid = 1'b0;

    function automatic logic [31:0] actual(input int p);
        case (p)
            0: return rd1_a;
            1: return rd2_a;
            2: return dbg_a;
            3: return {16'h0000, wc_a};
            4: return rd1_b;
            5: return rd2_b;
            6: return dbg_b;
            default: return {16'h0000, wc_b};
        endcase
    endfunction

    function automatic string pname(input int p);
        case (p)
            0: return "nobyp_ReadData1";
            1: return "nobyp_ReadData2";
            2: return "nobyp_DbgData";
            3: return "nobyp_WriteCount";
            4: return "byp_ReadData1";
            5: return "byp_ReadData2";
            6: return "byp_DbgData";
            default: return "byp_WriteCount";
        endcase
    endfunction

    // Monitor: compare everything queued for the current cycle away from the edge.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] a;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = actual(e.port);
            checks++;
            if (a !== e.exp) begin
                failures++;
                $display("FAIL %s actual=%h expected=%h time=%0t", pname(e.port), a, e.exp, $time);
            end
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit byp,
                                             input bit rw, input logic [4:0] wr,
                                             input logic [31:0] wd);
        if (byp && rw && wr != 5'd0 && idx == wr) return wd;
        if (idx == 5'd0) return 32'h0;
        return model_regs[idx];
    endfunction

    task automatic push(input int p, input logic [31:0] v);
        exp_t e;
        e.port = p;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // One clock cycle: drive, queue expectations from the pre-edge model, then advance the model.
    task automatic cyc(input bit r, input bit rw, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] dg);
        rst = r; RegWrite = rw; WriteReg = wr; WriteData = wd;
        ReadReg1 = a1; ReadReg2 = a2; DbgReg = dg;
        if (model_valid) begin
            push(0, exp_read(a1, 1'b0, rw, wr, wd));
            push(1, exp_read(a2, 1'b0, rw, wr, wd));
            push(2, exp_read(dg, 1'b0, rw, wr, wd));
            push(3, 32'(model_cnt));
            push(4, exp_read(a1, 1'b1, rw, wr, wd));
            push(5, exp_read(a2, 1'b1, rw, wr, wd));
            push(6, exp_read(dg, 1'b1, rw, wr, wd));
            push(7, 32'(model_cnt));
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
            model_cnt   = 0;
            model_valid = 1'b1;
        end else if (rw && wr != 5'd0) begin
            model_regs[wr] = wd;
            if (model_cnt < 65535) model_cnt++;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; RegWrite = 1'b0; WriteReg = 5'd0; WriteData = 32'h0;
        ReadReg1 = 5'd0; ReadReg2 = 5'd0; DbgReg = 5'd0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        // Reset state across several indices.
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd31, 5'd0);

        // Write then read.
        cyc(1'b0, 1'b1, 5'd8, 32'hf0f0ffff, 5'd8, 5'd9, 5'd8);
        cyc(1'b0, 1'b1, 5'd9, 32'h0000f0f0, 5'd8, 5'd9, 5'd9);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 5'd8);

        // Reset clears written registers.
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 5'd9);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 5'd8);

        // r0 immutable, count unchanged.
        cyc(1'b0, 1'b1, 5'd4, 32'h0000abcd, 5'd4, 5'd0, 5'd0);
        cyc(1'b0, 1'b1, 5'd0, 32'hdeadbeef, 5'd0, 5'd0, 5'd0);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd4, 5'd0);

        // Read-during-write: no-bypass sees old value, bypass sees new one.
        cyc(1'b0, 1'b1, 5'd5, 32'h00000011, 5'd1, 5'd2, 5'd3);
        cyc(1'b0, 1'b1, 5'd5, 32'h00000022, 5'd5, 5'd5, 5'd5);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);

        // Reset beats write.
        cyc(1'b1, 1'b1, 5'd3, 32'h00000055, 5'd3, 5'd3, 5'd3);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);

        // Sweep every register, reading back on all ports.
        for (int i = 1; i < 32; i++) begin
            cyc(1'b0, 1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1), 5'(i));
        end
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
        end

        // Randomized traffic, including index 0 writes and occasional resets.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(49, 0) == 0), 1'($urandom), 5'($urandom_range(31, 0)),
                $urandom, 5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)),
                5'($urandom_range(31, 0)));
        end

        // Saturation of the write counter.
        for (int n = 0; n < 65540; n++) begin
            cyc(1'b0, 1'b1, 5'($urandom_range(31, 1)), $urandom,
                5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
        end
        cyc(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0, 5'd7);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
